muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit and controller for the execute stage.
- Accepts one MUL/UDIV/SDIV request from execute and iterates one bit per cycle.
- Holds execute (and everything upstream) via stall_o until the result is ready, then presents the result for one cycle alongside the ALU result path.
- Flushes from the pipeline abort it cleanly.

Parameters:
- WIDTH, 64, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  execute holds a valid mul/div instruction. Held high until done_o.
- op_i  input  2  operation: 00 = MUL (low WIDTH bits), 01 = UDIV, 10 = SDIV, 11 = reserved (treated as no request).
- srca_i  input  WIDTH  dividend / multiplicand (post-forwarding value).
- srcb_i  input  WIDTH  divisor / multiplier (post-forwarding value).
- flush_i  input  1  pipeline flush; aborts any operation in progress.
- stall_o  output  1  hold execute and upstream stages this cycle.
- done_o  output  1  result_o is valid this cycle; single-cycle pulse.
- result_o  output  WIDTH  quotient or product low half.
- busy_o  output  1  state is not IDLE (for debug/perf counters).

Behaviour:
- States are IDLE, BUSY and DONE.
- Reset (asynchronous) forces:
  - state = IDLE;
  - counter = 0;
  - done_o = 0;
  - result_o = 0;
  - busy_o = 0;
  - all internal operand/accumulator registers = 0.
- Start condition: state == IDLE, valid_i = 1, op_i != 11, flush_i = 0.
- On start:
  - latch the op code;
  - MUL: multiplicand = srca_i, multiplier = srcb_i, accumulator = 0.
  - UDIV: divisor = srcb_i, dividend = srca_i.
  - SDIV: divisor = |srcb_i|, dividend = |srca_i| (two's complement, taken as unsigned), and record neg = sign(a) XOR sign(b).
  - Remainder register = 0, counter = 0.
  - If op is a divide and srcb_i == 0, go to DONE with result 0 (AArch64 divide-by-zero yields 0). Otherwise go to BUSY.
- BUSY, MUL: each cycle, if multiplier bit0 = 1 then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1. Arithmetic is modulo 2^WIDTH.
- BUSY, UDIV/SDIV: restoring division, MSB first, one quotient bit per cycle:
  - {rem, dividend} shifted left by 1;
  - if rem >= divisor, then rem -= divisor and quotient bit = 1.
- counter increments each BUSY cycle. After WIDTH BUSY cycles (counter == WIDTH-1 on the last one), go to DONE.
- Entering DONE registers result_o:
  - MUL: acc.
  - UDIV: quotient.
  - SDIV: quotient, negated if neg = 1.
  - SDIV of INT_MIN by -1 needs no special case: it naturally yields INT_MIN (0x8000...0).
- DONE: done_o = 1 for exactly this cycle, stall_o = 0. Next state is IDLE unconditionally.
- result_o holds its value until the next DONE or reset.
- Latency: start in cycle 0, BUSY in cycles 1..WIDTH, done_o in cycle WIDTH+1. Divide-by-zero: done_o in cycle 1.
- stall_o (combinational) = start condition true OR state == BUSY. It is low in DONE and low when idle without a request.
- No new request is accepted in BUSY or DONE; valid_i in those states is ignored.
- The request is not re-accepted in the DONE cycle. Execute advances on that edge, so the next cycle sees the following instruction.
- flush_i = 1 in any state: next state = IDLE, done_o = 0 next cycle, and result_o is not updated. flush_i has priority over start, the BUSY iteration and DONE.
- Operand changes on srca_i/srcb_i after the start cycle have no effect, because operands are latched.
- op_i = 11 with valid_i = 1: no start and stall_o = 0. Decode never issues it.

Test Plan:
- MUL: a = 0x0000_0001_0000_0003, b = 0x5 -> done_o in cycle 65, result 0x0000_0005_0000_000F. stall_o is high in cycles 0..64 and low in cycle 65.
- MUL overflow: a = 0xFFFF_FFFF_FFFF_FFFF, b = 0xFFFF_FFFF_FFFF_FFFF -> result 0x1.
- UDIV: a = 100, b = 7 -> 14. SDIV: a = -100, b = 7 -> 0xFFFF_FFFF_FFFF_FFF2 (-14). SDIV: a = 0x8000_0000_0000_0000, b = -1 -> 0x8000_0000_0000_0000.
- Divide-by-zero: UDIV a = 42, b = 0 -> done_o in cycle 1, result 0, stall_o high only in cycle 0.
- Flush: start UDIV, assert flush_i in cycle 30 -> IDLE in cycle 31, no done_o pulse, result_o unchanged. A new MUL 3×4 accepted in cycle 31 gives 12 in cycle 96.
- Reset mid-BUSY: assert reset asynchronously in cycle 20 -> busy_o, stall_o, done_o and result_o drop to 0 immediately. After reset release, back-to-back requests (MUL, then UDIV on the cycle after done_o) both complete correctly.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit for the execute stage.
// Iterates one bit per cycle: shift-and-add multiply (low WIDTH bits of the
// product) and restoring division (unsigned, or signed via magnitudes plus a
// sign fix-up). Execute is held through stall_o until the single-cycle
// done_o pulse. A flush aborts an operation in progress without touching result_o.
module muldiv_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_UDIV = 2'b01,
    OP_SDIV = 2'b10,
    OP_NONE = 2'b11
  } op_t;

  state_t           state;
  op_t              opReg;
  logic [CW-1:0]    counter;
  logic             neg;

  // Multiply datapath registers.
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] acc;

  // Divide datapath registers; quotient bits shift into the low end of dividend.
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] rem;

  // Request decode.
  logic             startReq;
  logic             isDivReq;
  logic             divByZero;
  logic             srcaNeg;
  logic             srcbNeg;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;

  // One iteration of each algorithm, computed from the current registers.
  logic [WIDTH-1:0] accNext;
  logic [WIDTH:0]   remShift;
  logic             remGeq;
  logic [WIDTH-1:0] remSub;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quotNext;
  logic [WIDTH-1:0] finalResult;
  logic             lastIter;

  assign startReq  = (state == IDLE) && valid_i && (op_i != OP_NONE) && !flush_i;
  assign isDivReq  = (op_i == OP_UDIV) || (op_i == OP_SDIV);
  assign divByZero = (srcb_i == '0);

  // Magnitudes for signed divide; INT_MIN maps to itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign srcaNeg = srca_i[WIDTH-1];
  assign srcbNeg = srcb_i[WIDTH-1];
  assign absA    = srcaNeg ? (~srca_i + 1'b1) : srca_i;
  assign absB    = srcbNeg ? (~srcb_i + 1'b1) : srcb_i;

  // Shift-and-add step, modulo 2^WIDTH.
  assign accNext = multiplier[0] ? (acc + multiplicand) : acc;

  // Restoring-division step: remShift is one bit wider than rem because the
  // shifted partial remainder can exceed WIDTH bits before the compare. When
  // the compare succeeds the difference is below the divisor, so WIDTH bits hold it.
  assign remShift = {rem, dividend[WIDTH-1]};
  assign remGeq   = (remShift >= {1'b0, divisor});
  assign remSub   = remShift[WIDTH-1:0] - divisor;
  assign remNext  = remGeq ? remSub : remShift[WIDTH-1:0];
  assign quotNext = {dividend[WIDTH-2:0], remGeq};

  assign lastIter = (counter == LAST_COUNT);

  // Stall while a request is being accepted or iterating. Gating with reset
  // releases the pipeline immediately on an asynchronous reset, even while
  // execute still presents its request.
  assign stall_o = !reset && (startReq || (state == BUSY));

  // Select the value registered into result_o on the final iteration.
  always_comb begin
    // NOTE: assign a default before the case so every path drives the
    // signal; a missing branch would otherwise infer a latch.
    finalResult = accNext;
    case (opReg)
      OP_MUL:  finalResult = accNext;
      OP_UDIV: finalResult = quotNext;
      OP_SDIV: finalResult = neg ? (~quotNext + 1'b1) : quotNext;
      default: finalResult = accNext;
    endcase
  end

  // Sequencer FSM and datapath: accept, iterate, present, abort on flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, matching the hardware.
      state        <= IDLE;
      opReg        <= OP_MUL;
      counter      <= '0;
      neg          <= 1'b0;
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      divisor      <= '0;
      dividend     <= '0;
      rem          <= '0;
      done_o       <= 1'b0;
      result_o     <= '0;
      busy_o       <= 1'b0;
    end else if (flush_i) begin
      // Abort wins over start, iteration and completion; result_o is kept.
      state   <= IDLE;
      counter <= '0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (startReq) begin
            opReg        <= op_t'(op_i);
            counter      <= '0;
            rem          <= '0;
            acc          <= '0;
            multiplicand <= srca_i;
            multiplier   <= srcb_i;
            neg          <= (op_i == OP_SDIV) && (srcaNeg ^ srcbNeg);
            divisor      <= (op_i == OP_SDIV) ? absB : srcb_i;
            dividend     <= (op_i == OP_SDIV) ? absA : srca_i;
            busy_o       <= 1'b1;
            if (isDivReq && divByZero) begin
              // Divide by zero completes at once with a zero result.
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= '0;
            end else begin
              state <= BUSY;
            end
          end
        end

        BUSY: begin
          counter <= counter + 1'b1;
          if (opReg == OP_MUL) begin
            acc          <= accNext;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
          end else begin
            rem      <= remNext;
            dividend <= quotNext;
          end
          if (lastIter) begin
            state    <= DONE;
            done_o   <= 1'b1;
            result_o <= finalResult;
          end
        end

        DONE: begin
          // Execute advances on this edge, so the held request is not re-taken.
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
